// File: rtl/power_trigger_mc.sv
// rtl/power_trigger_mc.sv - multi-channel |I|+|Q| moving-average packet power trigger with hysteresis
// Optional feature macro POWER_TRIGGER_PEAK_EN adds the peak_power port and per-channel peak tracking.
module power_trigger_mc #(
  parameter int         NUM_CH            = 2,
  parameter int         SAMPLE_W          = 16,
  parameter int         AVG_LOG2          = 4,
  parameter logic [7:0] SR_POWER_THRES    = 8'd3,
  parameter logic [7:0] SR_POWER_WINDOW   = 8'd4,
  parameter logic [7:0] SR_SKIP_SAMPLE    = 8'd5,
  parameter logic [7:0] SR_POWER_THRES_LO = 8'd6,
  parameter logic [7:0] SR_POWER_MODE     = 8'd7
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic [NUM_CH*2*SAMPLE_W-1:0]   sample_in,
  input  logic                           sample_in_strobe,
  output logic [NUM_CH-1:0]              trigger_ch,
  output logic                           trigger
`ifdef POWER_TRIGGER_PEAK_EN
  ,
  output logic [NUM_CH*(SAMPLE_W+1)-1:0] peak_power
`endif
);
  localparam int MAG_W = SAMPLE_W + 1;
  localparam int SUM_W = MAG_W + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;

  typedef enum logic [1:0] {ST_SKIP, ST_IDLE, ST_PACKET} state_t;

  logic        accept;
  logic [15:0] thres_hi_q, thres_lo_q, window_q, thres_lo_eff;
  logic [31:0] num_skip_q, skip_cnt_q;
  logic        mode_q, mode_act_q, flush_pend_q, skip_done, trigger_q;

  logic [SAMPLE_W-2:0] abs_i_q [NUM_CH];
  logic [SAMPLE_W-2:0] abs_q_q [NUM_CH];
  logic [MAG_W-1:0]    dl_q    [NUM_CH][DEPTH];
  logic [SUM_W-1:0]    sum_q   [NUM_CH];
  logic [SUM_W-1:0]    sum_d   [NUM_CH];
  logic [MAG_W-1:0]    mag     [NUM_CH];
  logic [MAG_W-1:0]    avg     [NUM_CH];
  logic [NUM_CH-1:0]   avg_gt_hi, avg_lt_lo, trig_ch_q;
  logic [15:0]         low_cnt_q [NUM_CH];
  state_t              st_q      [NUM_CH];
`ifdef POWER_TRIGGER_PEAK_EN
  logic [MAG_W-1:0]    peak_q    [NUM_CH];
`endif

  // abs(-2^(W-1)) would need W bits; saturate so |I|+|Q| stays within W+1 bits
  function automatic logic [SAMPLE_W-2:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1]) return x[SAMPLE_W-2:0];
    if (x[SAMPLE_W-2:0] == '0) return '1;
    return (SAMPLE_W-1)'(-x);
  endfunction

  assign accept       = enable & sample_in_strobe;
  assign thres_lo_eff = (thres_lo_q < thres_hi_q) ? thres_lo_q : thres_hi_q;
  assign skip_done    = (33'(skip_cnt_q) + 33'd1) >= 33'(num_skip_q);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mag[c]       = MAG_W'(abs_i_q[c]) + MAG_W'(abs_q_q[c]);
      sum_d[c]     = sum_q[c] + SUM_W'(mag[c]) - SUM_W'(dl_q[c][DEPTH-1]);
      avg[c]       = MAG_W'(sum_q[c] >> AVG_LOG2);
      avg_gt_hi[c] = 32'(avg[c]) > 32'(thres_hi_q);
      avg_lt_lo[c] = 32'(avg[c]) < 32'(thres_lo_eff);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thres_hi_q   <= 16'd100;
      thres_lo_q   <= 16'd80;
      window_q     <= 16'd80;
      num_skip_q   <= '0;
      mode_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (set_stb) begin
        case (set_addr)
          SR_POWER_THRES:    thres_hi_q <= set_data[15:0];
          SR_POWER_THRES_LO: thres_lo_q <= set_data[15:0];
          SR_POWER_WINDOW:   window_q   <= set_data[15:0];
          SR_SKIP_SAMPLE:    num_skip_q <= set_data;
          SR_POWER_MODE:     mode_q     <= set_data[0];
          default: ;
        endcase
      end
      // a skip write is remembered until the next accept performs the flush
      if (set_stb && set_addr == SR_SKIP_SAMPLE) flush_pend_q <= 1'b1;
      else if (accept)                           flush_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skip_cnt_q <= '0;
      mode_act_q <= 1'b0;
      trig_ch_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        abs_i_q[c]   <= '0;
        abs_q_q[c]   <= '0;
        sum_q[c]     <= '0;
        low_cnt_q[c] <= '0;
        st_q[c]      <= ST_SKIP;
        for (int d = 0; d < DEPTH; d++) dl_q[c][d] <= '0;
`ifdef POWER_TRIGGER_PEAK_EN
        peak_q[c]    <= '0;
`endif
      end
    end else if (accept) begin
      mode_act_q <= mode_q;
      for (int c = 0; c < NUM_CH; c++) begin
        abs_i_q[c] <= sat_abs(sample_in[c*2*SAMPLE_W + 2*SAMPLE_W-1 -: SAMPLE_W]);
        abs_q_q[c] <= sat_abs(sample_in[c*2*SAMPLE_W + SAMPLE_W-1 -: SAMPLE_W]);
      end
      if (flush_pend_q) begin
        skip_cnt_q <= '0;
        trig_ch_q  <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          sum_q[c]     <= '0;
          low_cnt_q[c] <= '0;
          st_q[c]      <= ST_SKIP;
          for (int d = 0; d < DEPTH; d++) dl_q[c][d] <= '0;
`ifdef POWER_TRIGGER_PEAK_EN
          peak_q[c]    <= '0;
`endif
        end
      end else begin
        if (st_q[0] == ST_SKIP && !skip_done) skip_cnt_q <= skip_cnt_q + 32'd1;
        for (int c = 0; c < NUM_CH; c++) begin
          sum_q[c]   <= sum_d[c];
          dl_q[c][0] <= mag[c];
          for (int d = 1; d < DEPTH; d++) dl_q[c][d] <= dl_q[c][d-1];
          case (st_q[c])
            ST_SKIP: if (skip_done) st_q[c] <= ST_IDLE;
            ST_IDLE: begin
              if (avg_gt_hi[c]) begin
                trig_ch_q[c] <= 1'b1;
                low_cnt_q[c] <= '0;
                st_q[c]      <= ST_PACKET;
`ifdef POWER_TRIGGER_PEAK_EN
                peak_q[c]    <= avg[c];
`endif
              end
            end
            ST_PACKET: begin
`ifdef POWER_TRIGGER_PEAK_EN
              if (avg[c] > peak_q[c]) peak_q[c] <= avg[c];
`endif
              if (avg_lt_lo[c]) begin
                if (low_cnt_q[c] >= window_q) begin
                  trig_ch_q[c] <= 1'b0;
                  st_q[c]      <= ST_IDLE;
                end else if (low_cnt_q[c] != 16'hFFFF) begin
                  low_cnt_q[c] <= low_cnt_q[c] + 16'd1;
                end
              end else begin
                low_cnt_q[c] <= '0;
              end
            end
            default: st_q[c] <= ST_SKIP;
          endcase
        end
      end
    end
  end

  // combined trigger follows trigger_ch every clock, not only on accepts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) trigger_q <= 1'b0;
    else          trigger_q <= mode_act_q ? (&trig_ch_q) : (|trig_ch_q);
  end

  assign trigger_ch = trig_ch_q;
  assign trigger    = trigger_q;

`ifdef POWER_TRIGGER_PEAK_EN
  always_comb begin
    peak_power = '0;
    for (int c = 0; c < NUM_CH; c++) peak_power[c*MAG_W +: MAG_W] = peak_q[c];
  end
`endif

endmodule
